// File: rtl/burst_ram_controller_if.sv
// Arbiter-side handshake and CellularRAM pad-side bus of burst_ram_controller.
// master: arbiter / pad wrapper side. slave: the controller.
interface burst_ram_controller_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              Req;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic              Ack;
    logic [DATA_W-1:0] WrData;
    logic              WrReady;
    logic [DATA_W-1:0] RdData;
    logic              RdValid;
    logic              Done;
    logic              Error;
    logic              Ready;
    logic              Busy;
    logic              MemClkEn;
    logic [ADDR_W-1:0] MemAdr;
    logic [DATA_W-1:0] MemDQOut;
    logic [DATA_W-1:0] MemDQIn;
    logic              MemDQOE;
    logic              MemCRE;
    logic              MemCE_n;
    logic              MemWE_n;
    logic              MemOE_n;
    logic              MemADV_n;
    logic              MemLB_n;
    logic              MemUB_n;
    logic              MemWait;

    modport master (
        output Req, ReqWrite, ReqAddr, WrData, MemDQIn, MemWait,
        input  Ack, WrReady, RdData, RdValid, Done, Error, Ready, Busy,
               MemClkEn, MemAdr, MemDQOut, MemDQOE, MemCRE,
               MemCE_n, MemWE_n, MemOE_n, MemADV_n, MemLB_n, MemUB_n
    );

    modport slave (
        input  Req, ReqWrite, ReqAddr, WrData, MemDQIn, MemWait,
        output Ack, WrReady, RdData, RdValid, Done, Error, Ready, Busy,
               MemClkEn, MemAdr, MemDQOut, MemDQOE, MemCRE,
               MemCE_n, MemWE_n, MemOE_n, MemADV_n, MemLB_n, MemUB_n
    );
endinterface

// File: rtl/burst_ram_controller.sv
// Synchronous-burst controller for Micron CellularRAM: power-up wait, BCR
// write, then BURST_LEN-word read/write bursts on a Req/Ack handshake.
// Optional feature macro BURST_WAIT_EN: honour MemWait in the data phase and
// abort with Error after WAIT_TIMEOUT consecutive stalls. Without it MemWait
// is ignored and Error stays low.
module burst_ram_controller #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 16,
    parameter int BURST_LEN    = 8,
    parameter int LATENCY      = 3,
    parameter int POWERUP_CYC  = 15000,
    parameter int WAIT_TIMEOUT = 64
) (
    input logic                    CLK,
    input logic                    Reset,
    burst_ram_controller_if.slave  bus
);
    localparam int CYC_W = $clog2(POWERUP_CYC + 8);
    localparam logic [2:0] BL_CODE = (BURST_LEN == 4)  ? 3'd1 :
                                     (BURST_LEN == 8)  ? 3'd2 :
                                     (BURST_LEN == 16) ? 3'd3 : 3'd4;
    // BCR: select [19:18]=10, sync mode, latency code, WAIT active-high,
    // WAIT asserted during delay, no wrap, burst length code.
    localparam logic [ADDR_W-1:0] BCR = ADDR_W'((2 << 18) | (LATENCY << 11) |
                                                (1 << 10) | (1 << 3) | int'(BL_CODE));

    typedef enum logic [2:0] {
        S_POWERUP, S_CFG_WRITE, S_CFG_RECOVER, S_IDLE,
        S_ADDRESS, S_LATENCY, S_DATA, S_END
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [5:0]        word_q, word_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
`ifdef BURST_WAIT_EN
    localparam int ST_W = $clog2(WAIT_TIMEOUT + 1);
    logic [ST_W-1:0]   stall_q, stall_d;
    logic              err_q, err_d;
`else
    logic              unused_wait;
    assign unused_wait = bus.MemWait;
`endif

    logic              xfer;
    logic              ack, wr_ready, done, error;
    logic              mem_clk_en, mem_dq_oe, mem_cre;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_dq_out;
    logic              ce_n, we_n, oe_n, adv_n, byte_n;

    // State and datapath registers; reset drops straight back to PowerUp.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_POWERUP;
            cyc_q      <= '0;
            word_q     <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef BURST_WAIT_EN
            stall_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            word_q     <= word_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef BURST_WAIT_EN
            stall_q    <= stall_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next-state, counters and all strobes decoded from the current state.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        word_d     = word_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        ready_d    = ready_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef BURST_WAIT_EN
        stall_d    = stall_q;
        err_d      = err_q;
`endif
        xfer       = 1'b0;
        ack        = 1'b0;
        wr_ready   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        mem_clk_en = 1'b0;
        mem_dq_oe  = 1'b0;
        mem_cre    = 1'b0;
        mem_adr    = '0;
        mem_dq_out = '0;
        ce_n       = 1'b1;
        we_n       = 1'b1;
        oe_n       = 1'b1;
        adv_n      = 1'b1;
        byte_n     = 1'b1;
        case (state_q)
            S_POWERUP: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(POWERUP_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = S_CFG_WRITE;
                end
            end
            S_CFG_WRITE: begin
                mem_cre = 1'b1;
                ce_n    = 1'b0;
                we_n    = 1'b0;
                adv_n   = (cyc_q != '0);
                mem_adr = BCR;
                cyc_d   = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(1)) begin
                    cyc_d   = '0;
                    state_d = S_CFG_RECOVER;
                end
            end
            S_CFG_RECOVER: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.Req) begin
                    ack     = 1'b1;
                    addr_d  = bus.ReqAddr;
                    wr_d    = bus.ReqWrite;
                    state_d = S_ADDRESS;
                end
            end
            S_ADDRESS: begin
                ce_n       = 1'b0;
                adv_n      = 1'b0;
                byte_n     = 1'b0;
                we_n       = !wr_q;
                mem_adr    = addr_q;
                mem_clk_en = 1'b1;
                cyc_d      = '0;
                word_d     = '0;
`ifdef BURST_WAIT_EN
                stall_d    = '0;
                err_d      = 1'b0;
`endif
                state_d    = S_LATENCY;
            end
            S_LATENCY: begin
                ce_n       = 1'b0;
                byte_n     = 1'b0;
                mem_clk_en = 1'b1;
                oe_n       = wr_q;
                mem_dq_oe  = wr_q;
                cyc_d      = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(LATENCY - 2)) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                ce_n       = 1'b0;
                byte_n     = 1'b0;
                mem_clk_en = 1'b1;
                oe_n       = wr_q;
                mem_dq_oe  = wr_q;
                mem_dq_out = wr_q ? bus.WrData : '0;
`ifdef BURST_WAIT_EN
                xfer = !bus.MemWait;
`else
                xfer = 1'b1;
`endif
                if (xfer) begin
                    wr_ready   = wr_q;
                    rd_valid_d = !wr_q;
                    if (!wr_q) rd_data_d = bus.MemDQIn;
                    word_d     = word_q + 6'd1;
                    if (word_q == 6'(BURST_LEN - 1)) state_d = S_END;
`ifdef BURST_WAIT_EN
                    stall_d    = '0;
                end else begin
                    // Stall counts consecutive WAIT cycles only.
                    stall_d = stall_q + ST_W'(1);
                    if (stall_q == ST_W'(WAIT_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_END;
                    end
`endif
                end
            end
            S_END: begin
`ifdef BURST_WAIT_EN
                done  = !err_q;
                error = err_q;
`else
                done  = 1'b1;
`endif
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Ack      = ack;
    assign bus.WrReady  = wr_ready;
    assign bus.RdData   = rd_data_q;
    assign bus.RdValid  = rd_valid_q;
    assign bus.Done     = done;
    assign bus.Error    = error;
    assign bus.Ready    = ready_q;
    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.MemClkEn = mem_clk_en;
    assign bus.MemAdr   = mem_adr;
    assign bus.MemDQOut = mem_dq_out;
    assign bus.MemDQOE  = mem_dq_oe;
    assign bus.MemCRE   = mem_cre;
    assign bus.MemCE_n  = ce_n;
    assign bus.MemWE_n  = we_n;
    assign bus.MemOE_n  = oe_n;
    assign bus.MemADV_n = adv_n;
    assign bus.MemLB_n  = byte_n;
    assign bus.MemUB_n  = byte_n;
endmodule
